// File: rtl/mastermind_pkg.sv
// mastermind_pkg: shared game dimensions for guess entry, history store and scorer.
package mastermind_pkg;
    localparam int NUM_PEGS   = 4;
    localparam int PEG_W      = 3;
    localparam int NUM_COLORS = 6;
    localparam int MAX_TURNS  = 8;
    // wide enough to hold MAX_TURNS itself, so the final turn count is visible
    localparam int TURN_W     = $clog2(MAX_TURNS + 1);
endpackage

// File: rtl/btn_edge.sv
// btn_edge: rising-edge press detector; history resets high so a held button is not a press.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    logic btn_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) btn_q <= 1'b1;
        else       btn_q <= btn;
    assign press = btn & ~btn_q;
endmodule

// File: rtl/guess_entry.sv
// guess_entry: builds a 4-peg guess from buttons and emits one registered commit pulse per select.
module guess_entry
    import mastermind_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              btn_select,
    output logic [PEG_W-1:0]  guess0,
    output logic [PEG_W-1:0]  guess1,
    output logic [PEG_W-1:0]  guess2,
    output logic [PEG_W-1:0]  guess3,
    output logic              commit,
    output logic [1:0]        cursor,
    output logic [TURN_W-1:0] turn,
    output logic              game_over
);
    logic [4:0] btns, press;
    logic [NUM_PEGS-1:0][PEG_W-1:0] pegs;
    logic [PEG_W-1:0] cur_peg, peg_up, peg_dn;
    logic active, do_sel, do_col, do_cur;
    assign btns = {btn_select, btn_right, btn_left, btn_down, btn_up};
    for (genvar i = 0; i < 5; i++) begin : g_btn
        btn_edge u_edge (.clk(clk), .reset(reset), .btn(btns[i]), .press(press[i]));
    end
    assign game_over = (turn == TURN_W'(MAX_TURNS));
    assign active    = ~mode & ~game_over;
    // select wins outright; any up/down press blocks cursor movement that cycle
    assign do_sel = active & press[4];
    assign do_col = active & ~press[4] & (press[0] ^ press[1]);
    assign do_cur = active & ~press[4] & ~(press[0] | press[1]) & (press[2] ^ press[3]);
    assign cur_peg = pegs[cursor];
    assign peg_up  = (cur_peg == PEG_W'(NUM_COLORS - 1)) ? '0 : cur_peg + PEG_W'(1);
    assign peg_dn  = (cur_peg == '0) ? PEG_W'(NUM_COLORS - 1) : cur_peg - PEG_W'(1);
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            pegs   <= '0;
            cursor <= '0;
            turn   <= '0;
            commit <= 1'b0;
        end else begin
            commit <= do_sel;
            if (do_sel) begin
                turn   <= turn + TURN_W'(1);
                cursor <= '0;
            end else if (do_col) begin
                pegs[cursor] <= press[0] ? peg_up : peg_dn;
            end else if (do_cur) begin
                cursor <= press[3] ? cursor + 2'd1 : cursor - 2'd1;
            end
        end
    assign guess0 = pegs[0];
    assign guess1 = pegs[1];
    assign guess2 = pegs[2];
    assign guess3 = pegs[3];
endmodule
